gate_truth_checker: RTL

//  Hardware stimulus driver and response checker for any 2-input gate.

---
 rtl/gate_check_pkg.sv | 26 ++
 rtl/gate_check_settle_timer.sv | 30 +++
 rtl/gate_truth_checker.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gate_check_pkg.sv
// Shared types and constants for the 2-input gate truth-table checker.
package gate_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } gc_state_t;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned ERR_W       = 3;

    // Bit i is the expected gate output for input vector i = {b,a}.
    localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
    localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
    localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;
    localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;

    // Case inequality so an unknown or floating gate output is reported as a mismatch.
    function automatic logic is_mismatch(input logic observed, input logic expected);
        return (observed !== expected);
    endfunction

endpackage

// File: rtl/gate_check_settle_timer.sv
// Loadable down-counter that times how long each stimulus vector is held before sampling.
module gate_check_settle_timer
    import gate_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // Loaded with SETTLE_CYCLES-1 so expiry lands on the last DRIVE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(SETTLE_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Drives all four input vectors into a 2-input gate and checks its output against TRUTH.
// Optional fail_mask output is enabled by defining GATE_CHECK_FAIL_MASK_EN.
module gate_truth_checker
    import gate_check_pkg::*;
#(
    parameter int unsigned             SETTLE_CYCLES = 2,
    parameter logic [NUM_VECTORS-1:0]  TRUTH         = TT_OR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_out,
    output logic             dut_a,
    output logic             dut_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail
`ifdef GATE_CHECK_FAIL_MASK_EN
    ,
    output logic [NUM_VECTORS-1:0] fail_mask
`endif
);

    gc_state_t        state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic             dut_a_d, dut_b_d;
    logic             busy_d, done_d, pass_d;
    logic [ERR_W-1:0] err_d;
    logic [IDX_W-1:0] first_d;
    logic             load_c;
    logic             expired_c;
    logic             mismatch_c;
`ifdef GATE_CHECK_FAIL_MASK_EN
    logic [NUM_VECTORS-1:0] fail_mask_d;
`endif

    gate_check_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .expired_c (expired_c)
    );

    // Next-state, result and stimulus computation.
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        dut_a_d    = dut_a;
        dut_b_d    = dut_b;
        err_d      = err_count;
        first_d    = first_fail;
        load_c     = 1'b0;
        mismatch_c = is_mismatch(dut_out, TRUTH[idx]);
`ifdef GATE_CHECK_FAIL_MASK_EN
        fail_mask_d = fail_mask;
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                    load_c  = 1'b1;
`ifdef GATE_CHECK_FAIL_MASK_EN
                    fail_mask_d = '0;
`endif
                end
            end
            DRIVE: begin
                if (expired_c) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch_c) begin
                    err_d = err_count + ERR_W'(1);
                    if (err_count == '0) begin
                        first_d = idx;
                    end
`ifdef GATE_CHECK_FAIL_MASK_EN
                    fail_mask_d[idx] = 1'b1;
`endif
                end
                if (idx == IDX_W'(NUM_VECTORS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx + IDX_W'(1);
                    state_d = DRIVE;
                    load_c  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Stimulus only moves on DRIVE entry; DONE keeps the last vector applied.
        if (load_c) begin
            dut_a_d = idx_d[0];
            dut_b_d = idx_d[1];
        end

        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
`ifdef GATE_CHECK_FAIL_MASK_EN
            fail_mask  <= '0;
`endif
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            dut_a      <= dut_a_d;
            dut_b      <= dut_b_d;
            busy       <= busy_d;
            done       <= done_d;
            pass       <= pass_d;
            err_count  <= err_d;
            first_fail <= first_d;
`ifdef GATE_CHECK_FAIL_MASK_EN
            fail_mask  <= fail_mask_d;
`endif
        end
    end

endmodule
